// File: rtl/cpu_pkg.sv
// Shared core definitions: ALU op encodings, default datapath widths and
// the forward-source select used by the operand forwarding muxes.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM, then MEM/WB, else the stored register value.
// Register 0 is never forwarded since it is hardwired to zero in the register file.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0]     stored,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     value
);

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_NONE;
    if (idx != '0) begin
      if (exmem_regwrite && (exmem_rd == idx)) begin
        sel = FWD_EXMEM;
      end else if (memwb_regwrite && (memwb_rd == idx)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    value = stored;
    case (sel)
      FWD_EXMEM: value = exmem_result;
      FWD_MEMWB: value = memwb_result;
      default:   value = stored;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB; stall holds, flush bubbles.
// Optional LOAD_USE_DETECT_EN: internal load-use detection that bubbles EX and raises ld_use_stall.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int ALUOP_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [4:0]                id_shamt,
  input  logic [ALUOP_WIDTH-1:0]    id_aluop,
  input  logic                      id_alusrc,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      id_memwrite,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_operand1,
  output logic [DATA_WIDTH-1:0]     ex_operand2,
  output logic [ALUOP_WIDTH-1:0]    ex_aluop,
  output logic [4:0]                ex_shamt,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_regwrite,
  output logic                      ex_memread,
  output logic                      ex_memwrite,
  output logic                      ld_use_stall
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [4:0]                shamt;
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic                      alusrc;
    logic                      regwrite;
    logic                      memread;
    logic                      memwrite;
  } idex_t;

  idex_t q;
  idex_t id_in;
  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;
  logic                  bubble;
  logic                  is_shift;

  always_comb begin
    id_in          = '0;
    id_in.valid    = id_valid;
    id_in.rs       = id_rs;
    id_in.rt       = id_rt;
    id_in.rd       = id_rd;
    id_in.rs_data  = id_rs_data;
    id_in.rt_data  = id_rt_data;
    id_in.imm      = id_imm;
    id_in.shamt    = id_shamt;
    id_in.aluop    = id_aluop;
    id_in.alusrc   = id_alusrc;
    id_in.regwrite = id_regwrite;
    id_in.memread  = id_memread;
    id_in.memwrite = id_memwrite;
  end

`ifdef LOAD_USE_DETECT_EN
  assign ld_use_stall = q.valid & q.memread & (q.rd != '0) & id_valid &
                        ((q.rd == id_rs) | (q.rd == id_rt));
`else
  assign ld_use_stall = 1'b0;
`endif

  assign bubble = flush | ld_use_stall;

  // During stall the stored sources refresh with forwarded values so a producer
  // leaving MEM/WB mid-stall is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (stall) begin
      q.rs_data <= fwd_rs;
      q.rt_data <= fwd_rt;
    end else begin
      q <= id_in;
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs (
    .idx(q.rs), .stored(q.rs_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(fwd_rs)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rt (
    .idx(q.rt), .stored(q.rt_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(fwd_rt)
  );

  // The ALU shifts operand1, so shifts route rt there.
  assign is_shift = (q.aluop == ALUOP_WIDTH'(ALU_SLL)) || (q.aluop == ALUOP_WIDTH'(ALU_SRL));

  assign ex_valid      = q.valid;
  assign ex_operand1   = is_shift ? fwd_rt : fwd_rs;
  assign ex_operand2   = q.alusrc ? q.imm : fwd_rt;
  assign ex_aluop      = q.aluop;
  assign ex_shamt      = q.shamt;
  assign ex_store_data = fwd_rt;
  assign ex_rd         = q.rd;
  assign ex_regwrite   = q.regwrite;
  assign ex_memread    = q.memread;
  assign ex_memwrite   = q.memwrite;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, load, forwarding priority, shift/imm, stall, flush, load-use.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_aluop;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ld_use_stall;
  logic [31:0] ex_operand1, ex_operand2, ex_store_data;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_shamt, ex_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
    .ex_aluop(ex_aluop), .ex_shamt(ex_shamt), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ld_use_stall(ld_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    id_rs_data = 32'h1234; id_rt_data = 32'h5678; id_imm = 32'h9;
    id_shamt = 5'd4; id_aluop = 4'd1; id_alusrc = 0;
    id_regwrite = 1; id_memread = 1; id_memwrite = 1;
    no_fwd();

    // Reset with nonzero ID fields
    tick(); tick();
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_regwrite", {31'b0, ex_regwrite}, 32'd0);
    chk("rst_aluop", {28'b0, ex_aluop}, 32'd0);
    chk("rst_op1", ex_operand1, 32'd0);
    chk("rst_op2", ex_operand2, 32'd0);
    chk("rst_rd", {27'b0, ex_rd}, 32'd0);

    // Basic load: SUB 5, 3
    rst = 0;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rs_data = 32'd5; id_rt_data = 32'd3;
    id_aluop = 4'd1; id_alusrc = 0; id_memread = 0; id_memwrite = 0;
    tick();
    chk("load_op1", ex_operand1, 32'd5);
    chk("load_op2", ex_operand2, 32'd3);
    chk("load_valid", {31'b0, ex_valid}, 32'd1);
    chk("load_aluop", {28'b0, ex_aluop}, 32'd1);
    chk("load_rd", {27'b0, ex_rd}, 32'd3);
    chk("load_store", ex_store_data, 32'd3);

    // Double forward on rs=4: EX/MEM wins, then MEM/WB alone
    id_rs = 5'd4; id_rs_data = 32'h11; id_aluop = 4'd0;
    tick();
    exmem_regwrite = 1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1 chk("fwd_both", ex_operand1, 32'hAA);
    exmem_regwrite = 0;
    #1 chk("fwd_memwb", ex_operand1, 32'hBB);

    // rs=0 never forwards
    id_rs = 5'd0; id_rs_data = 32'h22;
    exmem_regwrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    tick();
    chk("fwd_r0", ex_operand1, 32'h22);
    no_fwd();

    // SLL: operand1 takes forwarded rt
    id_rs = 5'd1; id_rs_data = 32'd5; id_rt = 5'd2; id_rt_data = 32'h99;
    id_aluop = 4'd7; id_shamt = 5'd3;
    tick();
    memwb_regwrite = 1; memwb_rd = 5'd2; memwb_result = 32'h10;
    #1 chk("sll_op1", ex_operand1, 32'h10);
    chk("sll_shamt", {27'b0, ex_shamt}, 32'd3);
    no_fwd();

    // Immediate operand2; store data still forwarded rt
    id_aluop = 4'd0; id_alusrc = 1; id_imm = 32'hFFFF_FFF0;
    tick();
    exmem_regwrite = 1; exmem_rd = 5'd2; exmem_result = 32'h77;
    #1 chk("imm_op2", ex_operand2, 32'hFFFF_FFF0);
    chk("imm_store", ex_store_data, 32'h77);
    chk("imm_op1", ex_operand1, 32'd5);
    no_fwd();

    // Stall: MEM/WB value captured in cycle 1 survives cycle 2
    id_rs = 5'd6; id_rs_data = 32'h1; id_alusrc = 0; id_rd = 5'd7;
    tick();
    stall = 1;
    id_rs = 5'd9; id_rs_data = 32'hDEAD; id_aluop = 4'd1; id_rd = 5'd12;
    memwb_regwrite = 1; memwb_rd = 5'd6; memwb_result = 32'h55;
    tick();
    no_fwd();
    #1 chk("stall_c1_op1", ex_operand1, 32'h55);
    chk("stall_aluop", {28'b0, ex_aluop}, 32'd0);
    chk("stall_rd", {27'b0, ex_rd}, 32'd7);
    tick();
    chk("stall_c2_op1", ex_operand1, 32'h55);
    chk("stall_valid", {31'b0, ex_valid}, 32'd1);

    // Flush beats stall
    flush = 1;
    tick();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_op1", ex_operand1, 32'd0);
    chk("flush_regwrite", {31'b0, ex_regwrite}, 32'd0);
    stall = 0; flush = 0;

    // Load-use: lw to r8 in EX, ID reads r8
    id_valid = 1; id_rd = 5'd8; id_memread = 1; id_regwrite = 1;
    id_rs = 5'd1; id_rt = 5'd2; id_aluop = 4'd0;
    tick();
    chk("lw_memread", {31'b0, ex_memread}, 32'd1);
    id_rs = 5'd8; id_rd = 5'd9; id_memread = 0;
`ifdef LOAD_USE_DETECT_EN
    #1 chk("ldu_req", {31'b0, ld_use_stall}, 32'd1);
    tick();
    chk("ldu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("ldu_bubble_memread", {31'b0, ex_memread}, 32'd0);
    chk("ldu_clear", {31'b0, ld_use_stall}, 32'd0);
`else
    #1 chk("ldu_off", {31'b0, ld_use_stall}, 32'd0);
    tick();
    chk("ldu_off_valid", {31'b0, ex_valid}, 32'd1);
    chk("ldu_off_rd", {27'b0, ex_rd}, 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
